key_packer: RTL and testbench

//  Upstream feeder of the lookup3 hash pipeline. Takes memcache key bytes from the request parser
//  (one byte/cycle, valid/ready) and packs them little-endian into 12-byte chunks (k0,k1,k2).

---
 rtl/key_packer_pkg.sv | 48 ++++
 rtl/key_packer_out_slice.sv | 46 ++++
 rtl/key_packer.sv | 192 +++++++++++++++++++
 tb/tb_key_packer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_packer_pkg.sv
// ----------------------------------------------------------------------------
// key_packer_pkg
//   Shared definitions for the key packer: chunk geometry, FSM encoding,
//   the payload carried from the fill buffer to the output register, and the
//   byte-lane helper that places a key byte into a 12-byte chunk.
//   Lane mapping: fill index i lands in k[i/4][8*(i%4)+:8], so the first key
//   byte of a chunk ends up in k0[7:0] (little-endian, lookup3 order).
// ----------------------------------------------------------------------------
package key_packer_pkg;

    localparam int DATA_W      = 8;
    localparam int CHUNK_BYTES = 12;
    localparam int CHUNK_W     = DATA_W * CHUNK_BYTES;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_KEY  = 1'b1
    } state_e;

    // One emitted beat: three hash words plus per-chunk bookkeeping.
    typedef struct packed {
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [7:0]  rem;
        logic        first;
        logic        last;
        logic        err;
        logic [7:0]  key_length;
    } chunk_t;

    // Return 'chunk' with byte lane 'idx' replaced by 'data'.
    function automatic logic [CHUNK_W-1:0] lane_write(
        input logic [CHUNK_W-1:0] chunk,
        input logic [3:0]         idx,
        input logic [DATA_W-1:0]  data
    );
        logic [CHUNK_W-1:0] res;
        res = chunk;
        for (int i = 0; i < CHUNK_BYTES; i++) begin
            if (idx == 4'(i)) begin
                res[DATA_W*i +: DATA_W] = data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_packer_out_slice.sv
// ----------------------------------------------------------------------------
// key_packer_out_slice
//   Output register of the key packer. Holds one chunk with valid/ready
//   semantics: the payload stays stable while out_valid is high and
//   out_ready is low. The parent only asserts 'load' when the register is
//   empty or is being drained in the same cycle, so a load always wins.
// Ports
//   CLK, RST   clock, synchronous active-high reset (clears valid and payload)
//   load       capture 'din' this cycle
//   din        chunk payload from the fill buffer
//   out_ready  downstream consumes the held chunk
//   out_valid  a chunk is held
//   dout       held chunk payload
// ----------------------------------------------------------------------------
module key_packer_out_slice
    import key_packer_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   load,
    input  chunk_t din,
    input  logic   out_ready,
    output logic   out_valid,
    output chunk_t dout
);

    logic   vld_p1;
    chunk_t data_p1;

    // ---- stage p1: output register ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= din;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign dout      = data_p1;

endmodule

// File: rtl/key_packer.sv
// ----------------------------------------------------------------------------
// key_packer
//   Front end of the lookup3 hash pipeline. Accepts memcache key bytes one
//   per cycle and packs them little-endian into 12-byte chunks (k0,k1,k2),
//   emitting one chunk per beat with its byte count, first/last markers,
//   the total kept key length on the last beat, and an error flag for keys
//   that were truncated (longer than MAX_KEY_LEN) or aborted by a new sop.
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   in_valid/ready  key byte handshake; in_data byte, in_sop/in_eop markers
//   out_valid/ready chunk handshake
//   out_k0..k2      chunk words, unused bytes zero
//   out_rem         bytes in this chunk (1..12)
//   out_first/last  chunk holds key byte 0 / chunk ends the key
//   out_key_length  kept key bytes, non-zero only with out_last
//   out_err         with out_last: key truncated or aborted
//   drop_cnt        saturating count of bytes seen while idle without sop
// ----------------------------------------------------------------------------
module key_packer
    import key_packer_pkg::*;
#(
    parameter int MAX_KEY_LEN = 250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_k0,
    output logic [31:0] out_k1,
    output logic [31:0] out_k2,
    output logic [7:0]  out_rem,
    output logic        out_first,
    output logic        out_last,
    output logic [7:0]  out_key_length,
    output logic        out_err,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] MAX_LEN  = 8'(MAX_KEY_LEN);
    localparam logic [3:0] FULL_CNT = 4'(CHUNK_BYTES);

    // Fill buffer. vld_p0 marks a closed chunk waiting to move out; a closed
    // chunk is always the last chunk of its key. A chunk that fills to 12
    // bytes without eop stays open and moves out together with the next key
    // byte, so the fill buffer is never empty while a key is in progress and
    // an abort or truncation always has a chunk to carry last/err.
    state_e             state;
    logic [CHUNK_W-1:0] buf_p0;
    logic [3:0]         cnt_p0;
    logic               first_p0;
    logic               err_p0;
    logic               vld_p0;
    logic [7:0]         len_p0;
    logic [15:0]        drop_cnt_r;

    logic   out_free;
    logic   buf_full;
    logic   len_full;
    logic   accept;
    logic   abort;
    logic   move_last;
    logic   move_full;
    logic   load;
    chunk_t chunk_d;
    chunk_t chunk_q;

    assign out_free = !out_valid || out_ready;
    assign buf_full = (cnt_p0 == FULL_CNT);
    assign len_full = (len_p0 == MAX_LEN);

    // In KEY a new sop is refused for one cycle while the partial chunk is
    // closed as aborted. A continuation byte that would start a new chunk can
    // only be taken when the full chunk can move out in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (state == ST_IDLE) begin
            in_ready = !vld_p0 || out_free;
        end else begin
            in_ready = !in_sop && !(buf_full && !len_full && !out_free);
        end
    end

    assign accept    = in_valid && in_ready;
    assign abort     = (state == ST_KEY) && in_valid && in_sop;
    assign move_last = vld_p0 && out_free;
    assign move_full = accept && (state == ST_KEY) && buf_full && !len_full;
    assign load      = move_last || move_full;

    always_comb begin
        chunk_d            = '0;
        chunk_d.k0         = buf_p0[31:0];
        chunk_d.k1         = buf_p0[63:32];
        chunk_d.k2         = buf_p0[95:64];
        chunk_d.rem        = {4'd0, cnt_p0};
        chunk_d.first      = first_p0;
        chunk_d.last       = vld_p0;
        chunk_d.err        = vld_p0 && err_p0;
        chunk_d.key_length = vld_p0 ? len_p0 : 8'd0;
    end

    // ---- stage p0: FSM, fill buffer, length and drop counters ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            buf_p0     <= '0;
            cnt_p0     <= 4'd0;
            first_p0   <= 1'b0;
            err_p0     <= 1'b0;
            vld_p0     <= 1'b0;
            len_p0     <= 8'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (move_last) begin
                vld_p0 <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_sop) begin
                            buf_p0   <= lane_write('0, 4'd0, in_data);
                            cnt_p0   <= 4'd1;
                            first_p0 <= 1'b1;
                            err_p0   <= 1'b0;
                            len_p0   <= 8'd1;
                            if (in_eop) begin
                                vld_p0 <= 1'b1;
                            end else begin
                                state <= ST_KEY;
                            end
                        end else if (drop_cnt_r != 16'hFFFF) begin
                            drop_cnt_r <= drop_cnt_r + 16'd1;
                        end
                    end
                end
                ST_KEY: begin
                    if (abort) begin
                        vld_p0 <= 1'b1;
                        err_p0 <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (accept) begin
                        // Bytes past MAX_LEN are consumed but not stored.
                        if (!len_full) begin
                            if (buf_full) begin
                                buf_p0   <= lane_write('0, 4'd0, in_data);
                                cnt_p0   <= 4'd1;
                                first_p0 <= 1'b0;
                            end else begin
                                buf_p0 <= lane_write(buf_p0, cnt_p0, in_data);
                                cnt_p0 <= cnt_p0 + 4'd1;
                            end
                            len_p0 <= len_p0 + 8'd1;
                        end
                        // An eop arriving with len already at MAX_LEN is an
                        // excess byte, hence the key was truncated.
                        if (in_eop) begin
                            vld_p0 <= 1'b1;
                            err_p0 <= len_full;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    key_packer_out_slice u_out_slice (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .din       (chunk_d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (chunk_q)
    );

    assign out_k0         = chunk_q.k0;
    assign out_k1         = chunk_q.k1;
    assign out_k2         = chunk_q.k2;
    assign out_rem        = chunk_q.rem;
    assign out_first      = chunk_q.first;
    assign out_last       = chunk_q.last;
    assign out_err        = chunk_q.err;
    assign out_key_length = chunk_q.key_length;
    assign drop_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_key_packer.sv
// ----------------------------------------------------------------------------
// tb_key_packer
//   Bench for key_packer: spec-derived beat table, hand-written corner
//   sequences (backpressure, truncation, strays, reset mid-key) and random
//   byte streams checked against a key-level reference model.
// ----------------------------------------------------------------------------
module tb_key_packer;

    localparam int MAXL = 250;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } byte_t;

    typedef struct packed {
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [7:0]  rem;
        logic        first;
        logic        last;
        logic        err;
        logic [7:0]  klen;
    } beat_t;

    typedef struct {
        string txt;
        int    hold;
        int    nbeats;
        beat_t exp;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_k0;
    logic [31:0] out_k1;
    logic [31:0] out_k2;
    logic [7:0]  out_rem;
    logic        out_first;
    logic        out_last;
    logic [7:0]  out_key_length;
    logic        out_err;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    byte_t      stim_q[$];
    beat_t      exp_q[$];
    beat_t      got_q[$];
    logic [7:0] cur_key[$];
    int         exp_drops;

    key_packer dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_k0         (out_k0),
        .out_k1         (out_k1),
        .out_k2         (out_k2),
        .out_rem        (out_rem),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_key_length (out_key_length),
        .out_err        (out_err),
        .drop_cnt       (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2,
                                 input int rem, input bit f, input bit l, input bit e, input int kl);
        beat_t b;
        b = {k0, k1, k2, 8'(rem), f, l, e, 8'(kl)};
        return b;
    endfunction

    function automatic beat_t cap();
        beat_t b;
        b = {out_k0, out_k1, out_k2, out_rem, out_first, out_last, out_err, out_key_length};
        return b;
    endfunction

    // Reference model: split a finished key into 12-byte chunks.
    task automatic flush_key(input bit aborted);
        int    n;
        int    kept;
        int    nch;
        int    idx;
        beat_t b;
        logic [31:0] w [3];
        n    = cur_key.size();
        kept = (n > MAXL) ? MAXL : n;
        nch  = (kept + 11) / 12;
        for (int c = 0; c < nch; c++) begin
            w[0] = 0; w[1] = 0; w[2] = 0;
            for (int j = 0; j < 12; j++) begin
                idx = c * 12 + j;
                if (idx < kept) w[j / 4] = w[j / 4] | (32'(cur_key[idx]) << (8 * (j % 4)));
            end
            b = mk(w[0], w[1], w[2], (kept - c * 12 > 12) ? 12 : kept - c * 12,
                   c == 0, c == nch - 1, (c == nch - 1) && (aborted || n > MAXL),
                   (c == nch - 1) ? kept : 0);
            exp_q.push_back(b);
        end
        cur_key.delete();
    endtask

    task automatic build_expected();
        bit in_key;
        in_key = 0;
        exp_drops = 0;
        exp_q.delete();
        cur_key.delete();
        foreach (stim_q[i]) begin
            if (stim_q[i].sop) begin
                if (in_key) flush_key(1'b1);
                cur_key.push_back(stim_q[i].d);
                in_key = 1;
            end else if (in_key) begin
                cur_key.push_back(stim_q[i].d);
            end else begin
                if (exp_drops < 65535) exp_drops++;
            end
            if (in_key && stim_q[i].eop) begin
                flush_key(1'b0);
                in_key = 0;
            end
        end
    endtask

    // '[' marks the next byte as sop, ']' marks the previous byte as eop.
    task automatic load_text(input string s);
        bit    sop_pend;
        byte   c;
        byte_t t;
        sop_pend = 0;
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h5B) begin
                sop_pend = 1;
            end else if (c == 8'h5D) begin
                t = stim_q.pop_back();
                t.eop = 1'b1;
                stim_q.push_back(t);
            end else begin
                t.d = c; t.sop = sop_pend; t.eop = 1'b0;
                stim_q.push_back(t);
                sop_pend = 0;
            end
        end
    endtask

    task automatic add_key(input int len, input bit with_eop);
        byte_t t;
        for (int i = 0; i < len; i++) begin
            t.d = 8'($urandom_range(255));
            t.sop = (i == 0);
            t.eop = with_eop && (i == len - 1);
            stim_q.push_back(t);
        end
    endtask

    task automatic gen_random(input int nseg);
        byte_t t;
        int    r;
        stim_q.delete();
        for (int s = 0; s < nseg; s++) begin
            r = $urandom_range(9);
            if (r == 0) begin
                for (int k = 0; k < $urandom_range(3, 1); k++) begin
                    t.d = 8'($urandom_range(255)); t.sop = 1'b0; t.eop = 1'($urandom_range(1));
                    stim_q.push_back(t);
                end
            end else if (r == 1) begin
                add_key($urandom_range(25, 1), 1'b0);
            end else if (r == 2) begin
                add_key($urandom_range(262, 240), 1'b1);
            end else begin
                add_key($urandom_range(40, 1), 1'b1);
            end
        end
        add_key($urandom_range(30, 1), 1'b1);
    endtask

    task automatic do_reset();
        in_valid = 0; in_data = 0; in_sop = 0; in_eop = 0; out_ready = 0;
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_stream(input int hold, input bit rnd_rdy, input bit rnd_gap, input bit do_rst);
        int    pos;
        int    cyc;
        int    budget;
        int    n;
        beat_t cur;
        beat_t snap;
        if (do_rst) do_reset();
        build_expected();
        got_q.delete();
        pos = 0; cyc = 0; snap = '0;
        budget = 20 * stim_q.size() + hold + 500;
        while ((pos < stim_q.size() || got_q.size() < exp_q.size()) && cyc < budget) begin
            if (pos < stim_q.size() && (!rnd_gap || $urandom_range(3) != 0)) begin
                in_valid = 1'b1; in_data = stim_q[pos].d;
                in_sop = stim_q[pos].sop; in_eop = stim_q[pos].eop;
            end else begin
                in_valid = 1'b0; in_data = 8'd0; in_sop = 1'b0; in_eop = 1'b0;
            end
            out_ready = (cyc < hold) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(1)) : 1'b1);
            #1;
            cur = cap();
            if (hold > 0 && cyc == hold - 4) snap = cur;
            if (hold > 0 && cyc == hold - 1) begin
                chk("hold_in_ready", 128'(in_ready), 128'(1'b0));
                chk("hold_out_valid", 128'(out_valid), 128'(1'b1));
                chk("hold_stable", 128'(cur), 128'(snap));
                chk("hold_all_accepted", 128'(pos), 128'(stim_q.size()));
            end
            if (out_valid && out_ready) got_q.push_back(cur);
            if (in_valid && in_ready) pos++;
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= budget) begin
            total++; bad++;
            $display("FAIL stream_timeout: sent=%0d of %0d beats=%0d of %0d", pos, stim_q.size(),
                     got_q.size(), exp_q.size());
        end
        in_valid = 1'b0; in_data = 8'd0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid && out_ready) got_q.push_back(cap());
            @(negedge CLK);
        end
        chk("beat_count", 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("model_beat%0d", i), 128'(got_q[i]), 128'(exp_q[i]));
        chk("drop_cnt", 128'(drop_cnt), 128'(exp_drops));
    endtask

    vec_t  vecs[7];
    int    bi;
    beat_t lastb;

    initial begin
        vecs[0] = '{txt: "[abcdefghijklm]", hold: 0, nbeats: 2,
                    exp: mk(32'h64636261, 32'h68676665, 32'h6C6B6A69, 12, 1, 0, 0, 0)};
        vecs[1] = '{txt: "", hold: 0, nbeats: 0,
                    exp: mk(32'h0000006D, 32'h0, 32'h0, 1, 0, 1, 0, 13)};
        vecs[2] = '{txt: "[x]", hold: 0, nbeats: 1,
                    exp: mk(32'h00000078, 32'h0, 32'h0, 1, 1, 1, 0, 1)};
        vecs[3] = '{txt: "[abcdefghijklm]", hold: 20, nbeats: 2,
                    exp: mk(32'h64636261, 32'h68676665, 32'h6C6B6A69, 12, 1, 0, 0, 0)};
        vecs[4] = '{txt: "", hold: 0, nbeats: 0,
                    exp: mk(32'h0000006D, 32'h0, 32'h0, 1, 0, 1, 0, 13)};
        vecs[5] = '{txt: "[hello[ab]", hold: 0, nbeats: 2,
                    exp: mk(32'h6C6C6568, 32'h0000006F, 32'h0, 5, 1, 1, 1, 5)};
        vecs[6] = '{txt: "", hold: 0, nbeats: 0,
                    exp: mk(32'h00006261, 32'h0, 32'h0, 2, 1, 1, 0, 2)};

        do_reset();
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_beat", 128'(cap()), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        @(negedge CLK);

        // Spec beat table
        bi = 0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].txt.len() != 0) begin
                load_text(vecs[i].txt);
                run_stream(vecs[i].hold, 1'b0, 1'b0, 1'b1);
                chk($sformatf("vec%0d_nbeats", i), 128'(got_q.size()), 128'(vecs[i].nbeats));
                bi = 0;
            end
            if (bi < got_q.size()) begin
                chk($sformatf("vec%0d_beat", i), 128'(got_q[bi]), 128'(vecs[i].exp));
            end else begin
                total++; bad++;
                $display("FAIL vec%0d_beat: got=none want=%h", i, vecs[i].exp);
            end
            bi++;
        end

        // Stray bytes while idle
        load_text("xyz");
        run_stream(0, 1'b0, 1'b0, 1'b1);
        chk("stray_beats", 128'(got_q.size()), 128'(0));
        chk("stray_drop_cnt", 128'(drop_cnt), 128'(3));

        // 260-byte key of 0x41, truncated to 250
        stim_q.delete();
        for (int i = 0; i < 260; i++) stim_q.push_back('{d: 8'h41, sop: (i == 0), eop: (i == 259)});
        run_stream(0, 1'b0, 1'b0, 1'b1);
        chk("long_nbeats", 128'(got_q.size()), 128'(21));
        lastb = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
        chk("long_last_beat", 128'(lastb),
            128'(mk(32'h41414141, 32'h41414141, 32'h00004141, 10, 0, 1, 1, 250)));

        // Reset in the middle of a key with the output register occupied
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h61 + i); in_sop = (i == 0); in_eop = 1'b0;
            out_ready = 1'b0;
            @(negedge CLK);
        end
        in_valid = 1'b0; in_sop = 1'b0;
        #1;
        chk("pre_rst_valid", 128'(out_valid), 128'(1'b1));
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_beat", 128'(cap()), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        @(negedge CLK);
        load_text("[x]");
        run_stream(0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_beat", 128'((got_q.size() > 0) ? got_q[0] : '0),
            128'(mk(32'h00000078, 32'h0, 32'h0, 1, 1, 1, 0, 1)));

        // Aborting a key whose buffer is exactly full
        load_text("[abcdefghijkl[z]");
        run_stream(0, 1'b0, 1'b0, 1'b1);
        chk("abort_full_beat", 128'((got_q.size() > 0) ? got_q[0] : '0),
            128'(mk(32'h64636261, 32'h68676665, 32'h6C6B6A69, 12, 1, 1, 1, 12)));

        // Random streams against the model
        for (int r = 0; r < 4; r++) begin
            gen_random(18);
            run_stream(0, r[0], r[1], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
